// File: rtl/cmp_seq_if.sv
// cmp_seq_if: start/done request bus for the multi-word compare sequencer.
// The master modport issues requests, the slave modport is the sequencer side.
interface cmp_seq_if #(
  parameter int NW = 2
);
  logic            start;
  logic            is_signed;
  logic [16*NW-1:0] a;
  logic [16*NW-1:0] b;
  logic            ready;
  logic            busy;
  logic            done;
  logic            eq;
  logic            gt;
  logic            lt;

  modport master (
    output start, is_signed, a, b,
    input  ready, busy, done, eq, gt, lt
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, busy, done, eq, gt, lt
  );
endinterface

// File: rtl/cmp_seq.sv
// cmp_seq: multi-word magnitude-compare sequencer.
// One 16-bit eq/gt/lt slice is reused over NW words, most significant word
// first, to compare two 16*NW-bit operands (signed or unsigned).
// Optional feature macro: CMP_SEQ_EARLY_EXIT_EN -- when defined, RUN ends on
// the first differing word; when undefined, all NW words are always scanned
// (fixed latency). Results are identical in both builds.
module cmp_seq #(
  parameter int NW = 2
) (
  input logic       clk,
  input logic       rst,
  cmp_seq_if.slave  bus
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [16*NW-1:0] a_q, a_d;
  logic [16*NW-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             rec_gt_q, rec_gt_d;
  logic             rec_lt_q, rec_lt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [15:0]      sl_a, sl_b;
  logic             sl_eq, sl_gt, sl_lt;
  logic             run_exit;

  // Shared comparator slice on the current word; the top word is offset to
  // binary in signed mode so an unsigned compare yields the signed order.
  always_comb begin
    sl_a = a_q[int'(idx_q)*16 +: 16];
    sl_b = b_q[int'(idx_q)*16 +: 16];
    if (sgn_q && (idx_q == IW'(NW-1))) begin
      sl_a[15] = ~sl_a[15];
      sl_b[15] = ~sl_b[15];
    end
    sl_eq = (sl_a == sl_b);
    sl_gt = (sl_a > sl_b);
    sl_lt = (sl_a < sl_b);
  end

  // Next-state and next-output computation for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    rec_gt_d  = rec_gt_q;
    rec_lt_d  = rec_lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    run_exit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          sgn_d     = bus.is_signed;
          idx_d     = IW'(NW-1);
          decided_d = 1'b0;
          rec_gt_d  = 1'b0;
          rec_lt_d  = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // Only the most significant differing word decides the result.
        if (!decided_q && !sl_eq) begin
          decided_d = 1'b1;
          rec_gt_d  = sl_gt;
          rec_lt_d  = sl_lt;
        end
`ifdef CMP_SEQ_EARLY_EXIT_EN
        run_exit = (idx_q == '0) || !sl_eq;
`else
        run_exit = (idx_q == '0);
`endif
        if (run_exit) begin
          eq_d    = ~decided_d;
          gt_d    = decided_d & rec_gt_d;
          lt_d    = decided_d & rec_lt_d;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: nonblocking assignments throughout, so every flop samples the
      // pre-edge values regardless of statement order.
      state_q   <= S_IDLE;
      // NOTE: operand registers are datapath storage and would not need a
      // reset, but they are cleared here so the block restarts from a known
      // state after an abort.
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      rec_gt_q  <= 1'b0;
      rec_lt_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      rec_gt_q  <= rec_gt_d;
      rec_lt_q  <= rec_lt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: randomized self-checking bench for cmp_seq (NW=2).
// Expected results come from whole-operand signed/unsigned arithmetic;
// expected latency from the position of the most significant differing word.
module tb_cmp_seq;

  localparam int NW = 2;
  localparam int W  = 16*NW;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [2:0] prev_res;  // {eq,gt,lt} the DUT should be holding

  cmp_seq_if #(.NW(NW)) bus ();

  cmp_seq #(.NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Reference: {eq,gt,lt} from whole-operand arithmetic.
  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic g, l;
    if (s) begin
      g = ($signed(a) > $signed(b));
      l = ($signed(a) < $signed(b));
    end else begin
      g = (a > b);
      l = (a < b);
    end
    return {~(g | l), g, l};
  endfunction

  // Reference: number of RUN cycles.
  function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    for (int w = NW-1; w >= 0; w--)
      if (a[w*16 +: 16] != b[w*16 +: 16]) return NW - w;
    return NW;
`else
    return NW + 0*int'(a[0] ^ b[0]);
`endif
  endfunction

  // Issue one request and check the whole transaction through the IDLE
  // cycle that follows DONE. 'interfere' pulses start with junk operands
  // in the first RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit interfere);
    logic [2:0] exp_res;
    int         exp_k;
    int         got_k;
    exp_res = model_res(a, b, s);
    exp_k   = model_k(a, b);
    @(negedge clk);
    check("ready_before_start", bus.ready, 1'b1);
    check("held_before_start", {bus.eq, bus.gt, bus.lt}, prev_res);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    check("cleared_on_start", {bus.eq, bus.gt, bus.lt}, 3'b000);
    got_k = 0;
    for (int c = 1; c <= 20; c++) begin
      if (interfere && c == 1) begin
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = rnd_op();
        bus.b         = rnd_op();
        bus.is_signed = ~s;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        got_k = c;
        break;
      end
      check("busy_in_run", bus.busy, 1'b1);
      check("zero_in_run", {bus.eq, bus.gt, bus.lt}, 3'b000);
    end
    check("run_cycles", got_k, exp_k);
    check("result", {bus.eq, bus.gt, bus.lt}, exp_res);
    check("ready_in_done", {bus.ready, bus.busy}, 2'b00);
    @(posedge clk);
    #1;
    check("done_single_pulse", bus.done, 1'b0);
    check("ready_after_done", bus.ready, 1'b1);
    check("held_after_done", {bus.eq, bus.gt, bus.lt}, exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    prev_res      = 3'b000;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.ready, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 6'b100000);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0);  // gt, decided on top word
    run_op(32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 1'b0);  // eq, full scan
    run_op(32'h1234_ABCD, 32'h1234_ABCD, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);  // -1 < 1
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);  // unsigned max > 1
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);  // signed extremes
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);  // start during RUN ignored

    // Abort with reset during RUN.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = 32'hABCD_0001;
    bus.b         = 32'hABCD_0001;
    bus.is_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", {bus.ready, bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 6'b100000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {bus.done, bus.ready}, 2'b01);
    end
    prev_res = 3'b000;
    run_op(32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0);

    // Back-to-back randomized requests, biased toward equal words.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra, rb;
      ra = rnd_op();
      rb = rnd_op();
      case ($urandom_range(3))
        0: rb = ra;
        1: rb[W-1 -: 16] = ra[W-1 -: 16];
        2: begin
          ra[W-1] = $urandom_range(1);
          rb[W-1] = ~ra[W-1];
        end
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(1)), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
